// File: rtl/flash_cmd_sequencer_pkg.sv
// Shared constants and helpers for the flash command sequencer:
// opcode bytes, descriptor op codes, FSM states and word-count decode.
package flash_cmd_pkg;

  localparam logic [7:0] OPC_READ   = 8'hAD;
  localparam logic [7:0] OPC_ERASE  = 8'hAE;
  localparam logic [7:0] OPC_INIT   = 8'hAF;
  localparam logic [7:0] OPC_INFO   = 8'hAC;
  localparam logic [7:0] OPC_LOG    = 8'hA0;
  localparam logic [7:0] OPC_BADBLK = 8'hB0;
  localparam logic [7:0] BB_END_IDX = 8'hFF;

  typedef enum logic [2:0] {
    OP_READ      = 3'd0,
    OP_ERASE     = 3'd1,
    OP_INIT_ADDR = 3'd2,
    OP_INFOPAGE  = 3'd3,
    OP_LOG       = 3'd4
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_BB2
  } state_e;

  function automatic logic is_flash_opc(input logic [7:0] opc);
    return (opc == OPC_READ) || (opc == OPC_ERASE) || (opc == OPC_INIT) ||
           (opc == OPC_INFO) || (opc == OPC_LOG);
  endfunction

  function automatic op_code_e opc2code(input logic [7:0] opc);
    case (opc)
      OPC_ERASE: return OP_ERASE;
      OPC_INIT:  return OP_INIT_ADDR;
      OPC_INFO:  return OP_INFOPAGE;
      OPC_LOG:   return OP_LOG;
      default:   return OP_READ;
    endcase
  endfunction

  // Number of 32-bit words making up one command; aw = address words.
  function automatic logic [4:0] opc_words(input logic [7:0] opc, input int aw);
    case (opc)
      OPC_ERASE:          return 5'(2 * aw);
      OPC_READ, OPC_INIT: return 5'(aw);
      OPC_INFO, OPC_LOG:  return 5'd1;
      default:            return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/flash_cmd_sequencer_if.sv
// Host command link, flash engine descriptor link, bad-block RAM port and
// status for the flash command sequencer. slave = sequencer side.
interface flash_cmd_sequencer_if #(
  parameter int ROW_W     = 24,
  parameter int NUM_CH    = 4,
  parameter int BB_ADDR_W = 9
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0]          cmd_word;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 op_valid;
  logic                 op_ready;
  logic [2:0]           op_code;
  logic [CH_W-1:0]      op_ch;
  logic [ROW_W-1:0]     op_addr_a;
  logic [ROW_W-1:0]     op_addr_b;
  logic [NUM_CH-1:0]    op_done;
  logic [NUM_CH-1:0]    ch_busy;
  logic                 bb_we;
  logic [BB_ADDR_W-1:0] bb_addr;
  logic [7:0]           bb_data;
  logic                 bb_done;
  logic                 err_seq;
  logic [7:0]           err_cnt;
  logic                 cmd_incomplete;

  modport master (
    output cmd_word, cmd_valid, op_ready, op_done,
    input  cmd_ready, op_valid, op_code, op_ch, op_addr_a, op_addr_b, ch_busy,
           bb_we, bb_addr, bb_data, bb_done, err_seq, err_cnt, cmd_incomplete
  );

  modport slave (
    input  cmd_word, cmd_valid, op_ready, op_done,
    output cmd_ready, op_valid, op_code, op_ch, op_addr_a, op_addr_b, ch_busy,
           bb_we, bb_addr, bb_data, bb_done, err_seq, err_cnt, cmd_incomplete
  );
endinterface

// File: rtl/flash_cmd_sequencer_watchdog.sv
// Inter-word timeout counter. Counts enabled, uncleared cycles and pulses
// o_expire on the LIMIT-th one; a clear in the same cycle suppresses expiry.
module flash_cmd_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en & ~i_clr & (r_cnt == CW'(LIMIT - 1));

  // idle-cycle counter, restarts on clear, disable or expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (i_clr || !i_en || o_expire) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/flash_cmd_sequencer.sv
// Flash command sequencer: assembles multi-word host commands into flash
// operation descriptors, issues them per channel with busy tracking, and
// streams bad-block table writes. Optional feature macro:
// FLASH_CMD_TIMEOUT_EN enables the inter-word timeout and cmd_incomplete.
module flash_cmd_sequencer
  import flash_cmd_pkg::*;
#(
  parameter int ROW_W       = 24,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 2400000,
  parameter int BB_ADDR_W   = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  flash_cmd_sequencer_if.slave bus
);
  localparam int             AW      = (ROW_W + 15) / 16;
  localparam int             NB      = ROW_W / 8;
  localparam int             CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0]     AW4     = 4'(AW);
  localparam logic [4:0]     NUM_CH5 = 5'(NUM_CH);

  if (ROW_W < 8 || ROW_W > 32 || (ROW_W % 8) != 0 || NUM_CH < 1 ||
      NUM_CH > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("flash_cmd_sequencer: illegal parameter set");
  end

  state_e               r_state, w_state_nxt;
  logic [7:0]           r_opc;
  logic [CH_W-1:0]      r_ch;
  logic [3:0]           r_k;
  logic [ROW_W-1:0]     r_addr_a, r_addr_b;
  logic [NUM_CH-1:0]    r_busy;
  logic [7:0]           r_err_cnt;
  logic                 r_err_seq, r_bb_done;
  logic                 r_bb_we;
  logic [BB_ADDR_W-1:0] r_bb_addr;
  logic [7:0]           r_bb_data, r_bb_idx, r_bb_lo;

  logic [7:0]      w_opc, w_idx;
  logic [15:0]     w_pay;
  logic [3:0]      w_k;
  logic [CH_W-1:0] w_ch;
  logic w_cmd_ready, w_acc, w_ch_ok, w_start, w_single, w_cont, w_last;
  logic w_load, w_merge, w_err, w_bb_wr, w_bb_end, w_fire, w_op_valid;
  logic w_expire;

  // Places one payload word (word number wk within an address) into the
  // address: byte 2k in addr[16k+:8], byte 2k+1 above it; bytes past ROW_W drop.
  function automatic logic [ROW_W-1:0] put_word(input logic [ROW_W-1:0] a,
                                                input logic [3:0] wk,
                                                input logic [15:0] p);
    logic [ROW_W-1:0] r;
    r = a;
    for (int b = 0; b < NB; b++)
      if (b / 2 == int'(wk)) r[8*b +: 8] = (b % 2 == 0) ? p[15:8] : p[7:0];
    return r;
  endfunction

  assign w_opc       = bus.cmd_word[31:24];
  assign w_idx       = bus.cmd_word[23:16];
  assign w_pay       = bus.cmd_word[15:0];
  assign w_k         = w_idx[3:0];
  assign w_ch        = w_idx[4 +: CH_W];
  assign w_ch_ok     = {1'b0, w_idx[7:4]} < NUM_CH5;
  assign w_cmd_ready = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_acc       = bus.cmd_valid & w_cmd_ready;
  assign w_start     = is_flash_opc(w_opc) & (w_k == 4'd0) & w_ch_ok;
  assign w_single    = opc_words(w_opc, AW) == 5'd1;
  assign w_cont      = (w_opc == r_opc) & w_ch_ok & (w_ch == r_ch) & (w_k == r_k);
  assign w_last      = ({1'b0, r_k} + 5'd1) == opc_words(r_opc, AW);
  assign w_op_valid  = (r_state == ST_ISSUE) & ~r_busy[r_ch];

  // next state, word classification and error detection
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_merge     = 1'b0;
    w_err       = 1'b0;
    w_bb_wr     = 1'b0;
    w_bb_end    = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_acc) begin
        if (w_opc == OPC_BADBLK) begin
          if (w_idx == BB_END_IDX) w_bb_end = 1'b1;
          else begin
            w_bb_wr     = 1'b1;
            w_state_nxt = ST_BB2;
          end
        end else if (w_start) begin
          w_load      = 1'b1;
          w_state_nxt = w_single ? ST_ISSUE : ST_COLLECT;
        end else begin
          w_err = 1'b1;
        end
      end
      ST_COLLECT: if (w_acc) begin
        if (w_cont) begin
          w_merge = 1'b1;
          if (w_last) w_state_nxt = ST_ISSUE;
        end else begin
          // a bad word that is itself a clean start opens a new command
          w_err = 1'b1;
          if (w_start) begin
            w_load      = 1'b1;
            w_state_nxt = w_single ? ST_ISSUE : ST_COLLECT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end else if (w_expire) begin
        w_state_nxt = ST_IDLE;
      end
      ST_ISSUE: begin
        w_fire = w_op_valid & bus.op_ready;
        if (w_fire) w_state_nxt = ST_IDLE;
      end
      ST_BB2:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state register and error status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_err_seq <= 1'b0;
      r_err_cnt <= '0;
      r_bb_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_seq <= w_err;
      r_bb_done <= w_bb_end;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // descriptor assembly; fields hold while ISSUE waits for op_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opc    <= '0;
      r_ch     <= '0;
      r_k      <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else if (w_load) begin
      r_opc    <= w_opc;
      r_ch     <= w_ch;
      r_k      <= 4'd1;
      r_addr_a <= put_word('0, 4'd0, w_pay);
      r_addr_b <= '0;
    end else if (w_merge) begin
      r_k <= r_k + 4'd1;
      if (r_k < AW4) r_addr_a <= put_word(r_addr_a, r_k, w_pay);
      else           r_addr_b <= put_word(r_addr_b, r_k - AW4, w_pay);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_busy
    // channel ownership: issue sets, op_done clears, set wins a tie
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               r_busy[c] <= 1'b0;
      else if (w_fire && r_ch == CH_W'(c))      r_busy[c] <= 1'b1;
      else if (bus.op_done[c])                  r_busy[c] <= 1'b0;
    end
  end

  // bad-block RAM writes: high byte on accept, low byte from BB2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bb_we   <= 1'b0;
      r_bb_addr <= '0;
      r_bb_data <= '0;
      r_bb_idx  <= '0;
      r_bb_lo   <= '0;
    end else if (w_bb_wr) begin
      r_bb_we   <= 1'b1;
      r_bb_addr <= BB_ADDR_W'({w_idx, 1'b0});
      r_bb_data <= w_pay[15:8];
      r_bb_idx  <= w_idx;
      r_bb_lo   <= w_pay[7:0];
    end else if (r_state == ST_BB2) begin
      r_bb_we   <= 1'b1;
      r_bb_addr <= BB_ADDR_W'({r_bb_idx, 1'b1});
      r_bb_data <= r_bb_lo;
    end else begin
      r_bb_we   <= 1'b0;
    end
  end

`ifdef FLASH_CMD_TIMEOUT_EN
  logic r_incomplete;

  flash_cmd_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_state == ST_COLLECT),
    .i_clr    (w_acc),
    .o_expire (w_expire)
  );

  // timed-out flag, held until the next accepted start word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_incomplete <= 1'b0;
    else if (w_load)                          r_incomplete <= 1'b0;
    else if (w_expire && r_state == ST_COLLECT) r_incomplete <= 1'b1;
  end

  assign bus.cmd_incomplete = r_incomplete;
`else
  assign w_expire           = 1'b0;
  assign bus.cmd_incomplete = 1'b0;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.op_valid  = w_op_valid;
  assign bus.op_code   = opc2code(r_opc);
  assign bus.op_ch     = r_ch;
  assign bus.op_addr_a = r_addr_a;
  assign bus.op_addr_b = r_addr_b;
  assign bus.ch_busy   = r_busy;
  assign bus.bb_we     = r_bb_we;
  assign bus.bb_addr   = r_bb_addr;
  assign bus.bb_data   = r_bb_data;
  assign bus.bb_done   = r_bb_done;
  assign bus.err_seq   = r_err_seq;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Self-checking bench for flash_cmd_sequencer (ROW_W=24, NUM_CH=4,
// TIMEOUT_CYC=16, BB_ADDR_W=9). Descriptors and RAM writes are checked
// against scoreboard queues filled as the commands are driven.
module tb_flash_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_err = 0;

  typedef struct packed {
    logic [2:0]  code;
    logic [1:0]  ch;
    logic [23:0] a;
    logic [23:0] b;
  } op_t;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } bb_t;

  op_t op_q[$];
  bb_t bb_q[$];

  always #5 clk = ~clk;

  flash_cmd_sequencer_if #(.ROW_W(24), .NUM_CH(4), .BB_ADDR_W(9)) ifc ();

  flash_cmd_sequencer #(
    .ROW_W(24), .NUM_CH(4), .TIMEOUT_CYC(16), .BB_ADDR_W(9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // scoreboard: descriptor handshakes and RAM writes
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.op_valid && ifc.op_ready) begin
        op_t g;
        g = '{ifc.op_code, ifc.op_ch, ifc.op_addr_a, ifc.op_addr_b};
        total++;
        if (op_q.size() == 0) begin
          bad++;
          $display("FAIL op_unexpected got code=%0d ch=%0d a=%h b=%h", g.code, g.ch, g.a, g.b);
        end else begin
          op_t e;
          e = op_q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL op_desc got code=%0d ch=%0d a=%h b=%h want code=%0d ch=%0d a=%h b=%h",
                     g.code, g.ch, g.a, g.b, e.code, e.ch, e.a, e.b);
          end
        end
      end
      if (ifc.bb_we) begin
        bb_t g;
        g = '{ifc.bb_addr, ifc.bb_data};
        total++;
        if (bb_q.size() == 0) begin
          bad++;
          $display("FAIL bb_unexpected got addr=%h data=%h", g.addr, g.data);
        end else begin
          bb_t e;
          e = bb_q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL bb_write got addr=%h data=%h want addr=%h data=%h", g.addr, g.data, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout total=%0d", total);
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    ifc.cmd_word  = w;
    ifc.cmd_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ifc.cmd_ready === 1'b1) begin
        tick();
        ifc.cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    ifc.cmd_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL send_accept word=%h got cmd_ready=%b want 1", w, ifc.cmd_ready);
  endtask

  task automatic done_ch(input int c);
    ifc.op_done = 4'(1 << c);
    tick();
    ifc.op_done = '0;
  endtask

  task automatic check_empty(input string name);
    total++;
    if (op_q.size() != 0 || bb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got op=%0d bb=%0d want 0 0", name, op_q.size(), bb_q.size());
      op_q.delete();
      bb_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if (ifc.cmd_ready !== 1'b1 || ifc.op_valid !== 1'b0 || ifc.op_code !== 3'd0 ||
        ifc.op_ch !== 2'd0 || ifc.op_addr_a !== 24'd0 || ifc.op_addr_b !== 24'd0 ||
        ifc.ch_busy !== 4'd0 || ifc.bb_we !== 1'b0 || ifc.bb_addr !== 9'd0 ||
        ifc.bb_data !== 8'd0 || ifc.bb_done !== 1'b0 || ifc.err_seq !== 1'b0 ||
        ifc.err_cnt !== 8'd0 || ifc.cmd_incomplete !== 1'b0) begin
      bad++;
      $display("FAIL %s got rdy=%b ov=%b code=%0d ch=%0d a=%h b=%h busy=%b we=%b ba=%h bd=%h done=%b es=%b ec=%0d inc=%b want rdy=1 rest 0",
               name, ifc.cmd_ready, ifc.op_valid, ifc.op_code, ifc.op_ch, ifc.op_addr_a, ifc.op_addr_b,
               ifc.ch_busy, ifc.bb_we, ifc.bb_addr, ifc.bb_data, ifc.bb_done, ifc.err_seq,
               ifc.err_cnt, ifc.cmd_incomplete);
    end
  endtask

  task automatic check_err(input string name);
    @(negedge clk);
    total++;
    if (ifc.err_seq !== 1'b1 || ifc.err_cnt !== 8'(exp_err)) begin
      bad++;
      $display("FAIL %s got err_seq=%b err_cnt=%0d want 1 %0d", name, ifc.err_seq, ifc.err_cnt, exp_err);
    end
    tick();
  endtask

  task automatic test_reset();
    ifc.cmd_word = '0; ifc.cmd_valid = 1'b0; ifc.op_ready = 1'b1; ifc.op_done = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_released");
    tick();
  endtask

  task automatic test_read();
    op_q.push_back('{3'd0, 2'd2, 24'h123456, 24'h0});
    ifc.op_ready = 1'b0;
    send(32'hAD205634);
    send(32'hAD211200);
    @(negedge clk);
    total++;
    if (ifc.op_valid !== 1'b1) begin
      bad++; $display("FAIL read_latency got op_valid=%b want 1", ifc.op_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (ifc.op_valid !== 1'b1 || ifc.op_code !== 3'd0 || ifc.op_ch !== 2'd2 || ifc.op_addr_a !== 24'h123456) begin
      bad++;
      $display("FAIL read_hold got ov=%b code=%0d ch=%0d a=%h want 1 0 2 123456",
               ifc.op_valid, ifc.op_code, ifc.op_ch, ifc.op_addr_a);
    end
    tick();
    ifc.op_ready = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (ifc.ch_busy !== 4'b0100 || ifc.op_valid !== 1'b0) begin
      bad++; $display("FAIL read_busy got busy=%b ov=%b want 0100 0", ifc.ch_busy, ifc.op_valid);
    end
    tick();
    done_ch(2);
    @(negedge clk);
    total++;
    if (ifc.ch_busy !== 4'b0000) begin
      bad++; $display("FAIL read_release got busy=%b want 0000", ifc.ch_busy);
    end
    tick();
    check_empty("read");
  endtask

  task automatic test_busy_erase();
    int low_cnt;
    op_q.push_back('{3'd0, 2'd1, 24'h0, 24'h0});
    send(32'hAD100000);
    send(32'hAD110000);
    tick();
    op_q.push_back('{3'd1, 2'd1, 24'h000001, 24'h0000FF});
    send(32'hAE100100);
    send(32'hAE110000);
    send(32'hAE12FF00);
    send(32'hAE130000);
    low_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ifc.op_valid === 1'b0 && ifc.ch_busy[1] === 1'b1) low_cnt++;
      tick();
    end
    total++;
    if (low_cnt != 6) begin
      bad++; $display("FAIL erase_wait_busy got low_cycles=%0d want 6", low_cnt);
    end
    done_ch(1);
    @(negedge clk);
    total++;
    if (ifc.op_valid !== 1'b1 || ifc.op_addr_b !== 24'h0000FF) begin
      bad++; $display("FAIL erase_after_done got ov=%b b=%h want 1 0000ff", ifc.op_valid, ifc.op_addr_b);
    end
    tick();
    @(negedge clk);
    total++;
    if (ifc.ch_busy !== 4'b0010) begin
      bad++; $display("FAIL erase_busy got busy=%b want 0010", ifc.ch_busy);
    end
    tick();
    done_ch(1);
    check_empty("erase");
  endtask

  task automatic test_set_wins();
    op_q.push_back('{3'd0, 2'd3, 24'hCCBBAA, 24'h0});
    send(32'hAD30AABB);
    send(32'hAD31CC00);
    ifc.op_done = 4'b1000;
    tick();
    ifc.op_done = '0;
    @(negedge clk);
    total++;
    if (ifc.ch_busy !== 4'b1000) begin
      bad++; $display("FAIL set_wins got busy=%b want 1000", ifc.ch_busy);
    end
    tick();
    done_ch(3);
    check_empty("set_wins");
  endtask

  task automatic test_out_of_order();
    int ov_seen;
    send(32'hAD000000);
    send(32'hAD020000);
    exp_err++;
    check_err("ooo_err");
    @(negedge clk);
    total++;
    if (ifc.err_seq !== 1'b0) begin
      bad++; $display("FAIL ooo_pulse got err_seq=%b want 0", ifc.err_seq);
    end
    tick();
    ov_seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (ifc.op_valid !== 1'b0) ov_seen++;
      tick();
    end
    total++;
    if (ov_seen != 0) begin
      bad++; $display("FAIL ooo_no_op got op_valid_cycles=%0d want 0", ov_seen);
    end
  endtask

  task automatic test_restart();
    send(32'hAD200000);
    op_q.push_back('{3'd1, 2'd0, 24'h000001, 24'h000002});
    send(32'hAE000100);
    exp_err++;
    check_err("restart_err");
    send(32'hAE010000);
    send(32'hAE020200);
    send(32'hAE030000);
    tick();
    tick();
    done_ch(0);
    check_empty("restart");
  endtask

  task automatic test_bad_words();
    send(32'h12000000); exp_err++; check_err("bad_opcode");
    send(32'hAD010000); exp_err++; check_err("bad_idle_index");
    send(32'hAD500000); exp_err++; check_err("bad_channel");
    send(32'hAD000000);
    send(32'hB0030000); exp_err++; check_err("badblk_in_collect");
    tick();
    check_empty("bad_words");
  endtask

  task automatic test_badblk();
    bb_q.push_back('{9'd6, 8'hA5});
    bb_q.push_back('{9'd7, 8'h5A});
    send(32'hB003A55A);
    @(negedge clk);
    total++;
    if (ifc.cmd_ready !== 1'b0 || ifc.bb_we !== 1'b1 || ifc.bb_addr !== 9'd6) begin
      bad++; $display("FAIL bb_first got rdy=%b we=%b addr=%h want 0 1 006", ifc.cmd_ready, ifc.bb_we, ifc.bb_addr);
    end
    tick();
    @(negedge clk);
    total++;
    if (ifc.bb_we !== 1'b1 || ifc.bb_addr !== 9'd7) begin
      bad++; $display("FAIL bb_second got we=%b addr=%h want 1 007", ifc.bb_we, ifc.bb_addr);
    end
    tick();
    bb_q.push_back('{9'h1FC, 8'h11});
    bb_q.push_back('{9'h1FD, 8'h22});
    send(32'hB0FE1122);
    repeat (3) tick();
    send(32'hB0FF0000);
    @(negedge clk);
    total++;
    if (ifc.bb_done !== 1'b1 || ifc.bb_we !== 1'b0) begin
      bad++; $display("FAIL bb_done got done=%b we=%b want 1 0", ifc.bb_done, ifc.bb_we);
    end
    tick();
    @(negedge clk);
    total++;
    if (ifc.bb_done !== 1'b0) begin
      bad++; $display("FAIL bb_done_pulse got done=%b want 0", ifc.bb_done);
    end
    tick();
    check_empty("badblk");
  endtask

  task automatic test_timeout();
`ifdef FLASH_CMD_TIMEOUT_EN
    send(32'hAF000000);
    repeat (15) @(negedge clk);
    @(negedge clk);
    total++;
    if (ifc.cmd_incomplete !== 1'b0) begin
      bad++; $display("FAIL timeout_early got incomplete=%b want 0", ifc.cmd_incomplete);
    end
    @(negedge clk);
    total++;
    if (ifc.cmd_incomplete !== 1'b1 || ifc.err_cnt !== 8'(exp_err)) begin
      bad++; $display("FAIL timeout_set got incomplete=%b err_cnt=%0d want 1 %0d",
                      ifc.cmd_incomplete, ifc.err_cnt, exp_err);
    end
    tick();
`else
    send(32'hAF000000);
    repeat (30) tick();
    @(negedge clk);
    total++;
    if (ifc.cmd_incomplete !== 1'b0 || ifc.cmd_ready !== 1'b1 || ifc.op_valid !== 1'b0) begin
      bad++; $display("FAIL no_timeout got inc=%b rdy=%b ov=%b want 0 1 0",
                      ifc.cmd_incomplete, ifc.cmd_ready, ifc.op_valid);
    end
    tick();
    op_q.push_back('{3'd2, 2'd0, 24'h0, 24'h0});
    send(32'hAF010000);
    tick();
    done_ch(0);
`endif
    op_q.push_back('{3'd3, 2'd0, 24'h0, 24'h0});
    send(32'hAC000000);
    @(negedge clk);
    total++;
    if (ifc.cmd_incomplete !== 1'b0 || ifc.op_valid !== 1'b1) begin
      bad++; $display("FAIL timeout_clear got inc=%b ov=%b want 0 1", ifc.cmd_incomplete, ifc.op_valid);
    end
    tick();
    tick();
    done_ch(0);
    check_empty("timeout");
  endtask

  task automatic test_err_sat();
    for (int n = 0; n < 300; n++) send(32'h55000000);
    @(negedge clk);
    total++;
    if (ifc.err_cnt !== 8'd255) begin
      bad++; $display("FAIL err_saturate got err_cnt=%0d want 255", ifc.err_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send(32'hAD100000);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_mid");
    tick();
    rst_n = 1'b1;
    tick();
    op_q.push_back('{3'd0, 2'd0, 24'h563412, 24'h0});
    send(32'hAD001234);
    send(32'hAD015600);
    tick();
    tick();
    done_ch(0);
    check_empty("reset_mid");
  endtask

  initial begin
    test_reset();
    test_read();
    test_busy_erase();
    test_set_wins();
    test_out_of_order();
    test_restart();
    test_bad_words();
    test_badblk();
    test_timeout();
    test_err_sat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

Parametrised successor to the flash command receiver. It sits between the host command link and the NAND flash engines. It assembles multi-word 32-bit commands into complete operation descriptors, checks word ordering, and enforces an inter-word timeout. It issues operations to a selectable flash channel over a valid/ready handshake with per-channel busy tracking, and streams bad-block table writes to the bad-block RAM.

## Interface
- ROW_W, 24, row-address width; multiple of 8, 8..32. AW = ceil(ROW_W/16) address words.
- NUM_CH, 4, flash channels, 1..16. CH_W = max(1, clog2(NUM_CH)).
- TIMEOUT_CYC, 2400000, idle cycles allowed between words of one command.
- BB_ADDR_W, 9, bad-block RAM address width.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_word  in  32  {opcode[31:24], index[23:16], payload[15:0]}
- cmd_valid  in  1  word present
- cmd_ready  out  1  word accepted when cmd_valid & cmd_ready
- op_valid  out  1  descriptor valid
- op_ready  in  1  engine accepts descriptor
- op_code  out  3  0 READ, 1 ERASE, 2 INIT_ADDR, 3 INFOPAGE, 4 LOG
- op_ch  out  CH_W  target channel
- op_addr_a / op_addr_b  out  ROW_W  start / finish row (op_addr_b is ERASE only, else 0)
- op_done  in  NUM_CH  one-cycle completion per channel
- ch_busy  out  NUM_CH  channel owns an issued operation
- bb_we  out  1  bad-block RAM write strobe
- bb_addr  out  BB_ADDR_W  RAM address
- bb_data  out  8  RAM data
- bb_done  out  1  one-cycle end-of-table pulse
- err_seq  out  1  one-cycle protocol error pulse
- err_cnt  out  8  saturating error count
- cmd_incomplete  out  1  level; a sequence timed out

## Operation
- Opcodes and word counts:
  - 0xAD READ: AW words.
  - 0xAE ERASE: 2·AW words (start address, then finish address).
  - 0xAF INIT_ADDR: AW words.
  - 0xAC INFOPAGE: 1 word.
  - 0xA0 LOG: 1 word.
  - 0xB0 BADBLK: per-word handling, see below.
- Index byte for flash opcodes: [3:0] = word number k, [7:4] = channel.
- Address byte packing: word k carries byte 2k in payload[15:8] and byte 2k+1 in payload[7:0]. Bytes at or above ROW_W/8 are ignored. The finish address restarts at byte 0 from word AW.
- FSM states:
  - IDLE: an index-0 word with a flash opcode loads the opcode, channel, and bytes. It goes to ISSUE if single-word, otherwise to COLLECT.
  - COLLECT: expects same opcode, same channel, k = expected. On the last word it goes to ISSUE.
  - ISSUE: cmd_ready=0. op_valid=1 only while ch_busy[op_ch]=0. On op_valid&op_ready it sets ch_busy[op_ch] and returns to IDLE.
  - BB2: cmd_ready=0 for the second RAM write.
- Sequence errors:
  - Triggers: a wrong k, opcode, or channel in COLLECT; an index≠0 flash word in IDLE; an unknown opcode; a channel ≥ NUM_CH.
  - Response: discard the partial command, pulse err_seq, increment err_cnt (saturate at 255), go to IDLE.
  - If the offending word is itself a valid index-0 start, it begins a new sequence in the same cycle.
- BADBLK, index i≠0xFF:
  - Cycle 1: bb_we=1, bb_addr=(i·2) truncated to BB_ADDR_W, bb_data=payload[15:8].
  - Cycle 2 (BB2): bb_addr=i·2+1, bb_data=payload[7:0].
  - Accepted in IDLE only; in COLLECT it is a sequence error.
- BADBLK, i=0xFF: pulse bb_done with no write.
- ch_busy: cleared by op_done[c]. If a set and a clear hit the same channel in the same cycle, the set wins.

## Timing
- Reset: every output is 0, except cmd_ready=1. State is IDLE, counters are 0.
- Latency: last word accepted in cycle N → op_valid in N+1 if the channel is free.
- op_valid, once high, holds all descriptor fields stable until op_ready.
- Timeout: the counter clears on each accepted word in COLLECT and increments otherwise. On reaching TIMEOUT_CYC it discards, sets cmd_incomplete, and goes to IDLE. cmd_incomplete stays high until the next accepted index-0 word. A timeout does not count in err_cnt.
- A word accepted in the same cycle as the timeout wins; the counter clears.
- Reset mid-operation aborts any sequence or write at once. No partial bb_we pulse is produced.

## Configuration
- FLASH_CMD_TIMEOUT_EN defined: timeout counter and cmd_incomplete are implemented as above.
- FLASH_CMD_TIMEOUT_EN undefined: no counter; cmd_incomplete is tied 0; COLLECT waits indefinitely.

## Structure
- Package flash_cmd_pkg holds:
  - opcode byte constants (OPC_READ=8'hAD, …);
  - the op_code enum and FSM state enum;
  - BB_END_IDX=8'hFF.
- Sub-module flash_cmd_watchdog: timeout counter with clear/enable inputs and an expire pulse. It is instantiated only under FLASH_CMD_TIMEOUT_EN.

## Test plan
- READ on channel 2, defaults: words 0xAD205634 then 0xAD211200 → op_valid in the cycle after word 2; op_code=0, op_ch=2, op_addr_a=0x123456.
- ERASE on channel 1 while ch_busy[1]=1:
  - Words: 0xAE100100, 0xAE110000, 0xAE12FF00, 0xAE130000.
  - op_valid stays low until op_done[1].
  - Then op_addr_a=0x000001, op_addr_b=0x0000FF.
- Out-of-order: 0xAD000000 then 0xAD020000 → err_seq pulse, err_cnt=1, no op_valid.
- Timeout with TIMEOUT_CYC=16: 0xAF000000, then 16 idle cycles → cmd_incomplete=1. It clears on the next 0xAC000000, which issues INFOPAGE.
- BADBLK: 0xB003A55A → bb_addr 6 with data 0xA5, then bb_addr 7 with data 0x5A on consecutive cycles. Then 0xB0FF0000 → bb_done pulse, no bb_we.
- Reset asserted mid-COLLECT → all outputs at reset values. A fresh READ then issues normally.
